// File: rtl/pr_timer.sv
// rtl/pr_timer.sv - bus-mapped down-counting timer with prescaler, one-shot/auto-reload modes and masked irq
module pr_timer #(
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [3:0]  mask,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CNT  = 2'd1,
        S_INT  = 2'd2
    } state_t;

    localparam logic [15:0] PSC_LAST = 16'(PRESCALE - 1);
    localparam logic [1:0]  A_CTRL   = 2'd0;
    localparam logic [1:0]  A_PRESET = 2'd1;
    localparam logic [1:0]  A_COUNT  = 2'd2;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_en;
    logic [1:0]  r_mode;
    logic        r_im;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic [15:0] r_psc;
    logic        r_irq_flag;

    logic [31:0] w_count_nxt;
    logic [15:0] w_psc_nxt;
    logic        w_flag_set;
    logic        w_flag_clr;
    logic        w_en_clr;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_tick;
    logic        w_auto_reload;
    logic [31:0] w_preset_merged;

    assign w_wr_ctrl     = sel && we && (addr == A_CTRL);
    assign w_wr_preset   = sel && we && (addr == A_PRESET);
    assign w_tick        = (r_psc == PSC_LAST);
    // Only MODE=1 reloads; the reserved encodings behave as one-shot.
    assign w_auto_reload = (r_mode == 2'd1);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_preset_merged[8*i +: 8] = mask[i] ? wdata[8*i +: 8] : r_preset[8*i +: 8];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_psc_nxt   = r_psc;
        w_flag_set  = 1'b0;
        w_flag_clr  = 1'b0;
        w_en_clr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_en) begin
                    w_count_nxt = r_preset;
                    w_psc_nxt   = 16'd0;
                    w_state_nxt = S_CNT;
                end
            end
            S_CNT: begin
                if (!r_en) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tick) begin
                    w_psc_nxt = 16'd0;
                    if (r_count <= 32'd1) begin
                        w_count_nxt = 32'd0;
                        w_flag_set  = 1'b1;
                        w_state_nxt = S_INT;
                    end else begin
                        w_count_nxt = r_count - 32'd1;
                    end
                end else begin
                    w_psc_nxt = r_psc + 16'd1;
                end
            end
            S_INT: begin
                if (w_auto_reload) begin
                    w_count_nxt = r_preset;
                    w_psc_nxt   = 16'd0;
                    w_flag_clr  = 1'b1;
                    w_state_nxt = S_CNT;
                end else begin
                    w_en_clr    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_count <= 32'd0;
            r_psc   <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_psc   <= w_psc_nxt;
        end
    end

    // Bus writes to CTRL override the FSM's EN clear and always drop the flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_en       <= 1'b0;
            r_mode     <= 2'd0;
            r_im       <= 1'b0;
            r_preset   <= 32'd0;
            r_irq_flag <= 1'b0;
        end else begin
            if (w_wr_ctrl && mask[0]) begin
                r_en   <= wdata[0];
                r_mode <= wdata[2:1];
                r_im   <= wdata[3];
            end else if (w_en_clr) begin
                r_en <= 1'b0;
            end
            if (w_wr_ctrl) begin
                r_irq_flag <= 1'b0;
            end else if (w_flag_set) begin
                r_irq_flag <= 1'b1;
            end else if (w_flag_clr) begin
                r_irq_flag <= 1'b0;
            end
            if (w_wr_preset) begin
                r_preset <= w_preset_merged;
            end
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (sel) begin
            case (addr)
                A_CTRL:   rdata = {28'd0, r_im, r_mode, r_en};
                A_PRESET: rdata = r_preset;
                A_COUNT:  rdata = r_count;
                default:  rdata = 32'd0;
            endcase
        end
    end

    assign irq = r_irq_flag & r_im;

endmodule

// File: tb/tb_pr_timer.sv
// tb/tb_pr_timer.sv - self-checking bench for pr_timer with arithmetic reference model
module tb_pr_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic        sel1, sel4;
    logic [31:0] rdata1, rdata4;
    logic        irq1, irq4;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    pr_timer #(.PRESCALE(1)) u_dut1 (
        .clk(clk), .reset(reset), .sel(sel1), .addr(addr), .we(we),
        .mask(mask), .wdata(wdata), .rdata(rdata1), .irq(irq1)
    );

    pr_timer #(.PRESCALE(4)) u_dut4 (
        .clk(clk), .reset(reset), .sel(sel4), .addr(addr), .we(we),
        .mask(mask), .wdata(wdata), .rdata(rdata4), .irq(irq4)
    );

    function automatic logic irq_of(input int d);
        return (d == 4) ? irq4 : irq1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; sel1 = 1'b0; sel4 = 1'b0; we = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic bus_write(input int d, input logic [1:0] a, input logic [31:0] v, input logic [3:0] m);
        @(negedge clk);
        addr = a; wdata = v; mask = m; we = 1'b1;
        if (d == 4) sel4 = 1'b1; else sel1 = 1'b1;
        @(negedge clk);
        we = 1'b0; sel1 = 1'b0; sel4 = 1'b0;
    endtask

    task automatic read_reg(input int d, input logic [1:0] a, output logic [31:0] v);
        addr = a; we = 1'b0;
        if (d == 4) sel4 = 1'b1; else sel1 = 1'b1;
        #1;
        v = (d == 4) ? rdata4 : rdata1;
        sel1 = 1'b0; sel4 = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        do_reset();
        for (int d = 1; d <= 4; d += 3) begin
            for (int a = 0; a < 4; a++) begin
                read_reg(d, 2'(a), v);
                n_total++;
                if (v !== 32'd0) $display("FAIL reset_rdata dut%0d addr%0d got %h want 0", d, a, v);
                else n_pass++;
            end
            n_total++;
            if (irq_of(d) !== 1'b0) $display("FAIL reset_irq dut%0d got %b want 0", d, irq_of(d));
            else n_pass++;
        end
    endtask

    task automatic test_bytelanes();
        logic [31:0] v;
        do_reset();
        bus_write(1, 2'd1, 32'h1234_5678, 4'b0101);
        read_reg(1, 2'd1, v);
        n_total++;
        if (v !== 32'h0034_0078) $display("FAIL preset_mask got %h want 00340078", v);
        else n_pass++;
        bus_write(1, 2'd2, 32'hFFFF_FFFF, 4'hF);
        read_reg(1, 2'd2, v);
        n_total++;
        if (v !== 32'd0) $display("FAIL count_ro got %h want 0", v);
        else n_pass++;
        bus_write(1, 2'd3, 32'hFFFF_FFFF, 4'hF);
        read_reg(1, 2'd3, v);
        n_total++;
        if (v !== 32'd0) $display("FAIL addr3_read got %h want 0", v);
        else n_pass++;
        bus_write(1, 2'd0, 32'hFFFF_FFF0, 4'hF);
        read_reg(1, 2'd0, v);
        n_total++;
        if (v !== 32'd0) $display("FAIL ctrl_upper got %h want 0", v);
        else n_pass++;
        addr = 2'd1; sel1 = 1'b0; #1;
        n_total++;
        if (rdata1 !== 32'd0) $display("FAIL nosel_read got %h want 0", rdata1);
        else n_pass++;
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        int exp_cnt [4] = '{3, 2, 1, 0};
        logic exp_irq [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        bus_write(1, 2'd1, 32'd3, 4'hF);
        bus_write(1, 2'd0, 32'h9, 4'hF);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            read_reg(1, 2'd2, v);
            n_total++;
            if (v !== 32'(exp_cnt[k])) $display("FAIL oneshot_count k%0d got %0d want %0d", k, v, exp_cnt[k]);
            else n_pass++;
            n_total++;
            if (irq1 !== exp_irq[k]) $display("FAIL oneshot_irq k%0d got %b want %b", k, irq1, exp_irq[k]);
            else n_pass++;
        end
        @(negedge clk);
        read_reg(1, 2'd0, v);
        n_total++;
        if (v !== 32'h8) $display("FAIL oneshot_ctrl got %h want 8", v);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_total++;
        if (irq1 !== 1'b1) $display("FAIL oneshot_irq_hold got %b want 1", irq1);
        else n_pass++;
        bus_write(1, 2'd0, 32'h8, 4'hF);
        n_total++;
        if (irq1 !== 1'b0) $display("FAIL oneshot_irq_clear got %b want 0", irq1);
        else n_pass++;
    endtask

    task automatic test_autoreload();
        logic [31:0] v;
        do_reset();
        bus_write(1, 2'd1, 32'd2, 4'hF);
        bus_write(1, 2'd0, 32'hB, 4'hF);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            read_reg(1, 2'd2, v);
            n_total++;
            if (v !== 32'(2 - (k % 3))) $display("FAIL reload_count k%0d got %0d want %0d", k, v, 2 - (k % 3));
            else n_pass++;
            n_total++;
            if (irq1 !== ((k % 3) == 2)) $display("FAIL reload_irq k%0d got %b want %b", k, irq1, (k % 3) == 2);
            else n_pass++;
        end
    endtask

    task automatic test_prescale();
        logic [31:0] v;
        do_reset();
        bus_write(4, 2'd1, 32'd0, 4'hF);
        bus_write(4, 2'd0, 32'h9, 4'hF);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_total++;
            if (irq4 !== (k == 4)) $display("FAIL psc4_irq k%0d got %b want %b", k, irq4, k == 4);
            else n_pass++;
        end
        read_reg(4, 2'd2, v);
        n_total++;
        if (v !== 32'd0) $display("FAIL psc4_count got %0d want 0", v);
        else n_pass++;
    endtask

    task automatic test_no_im();
        logic [31:0] v;
        do_reset();
        bus_write(1, 2'd1, 32'd2, 4'hF);
        bus_write(1, 2'd0, 32'h1, 4'hF);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_total++;
            if (irq1 !== 1'b0) $display("FAIL noim_irq k%0d got %b want 0", k, irq1);
            else n_pass++;
        end
        read_reg(1, 2'd0, v);
        n_total++;
        if (v !== 32'd0) $display("FAIL noim_ctrl got %h want 0", v);
        else n_pass++;
    endtask

    task automatic test_reset_midcount();
        logic [31:0] v;
        do_reset();
        bus_write(1, 2'd1, 32'd10, 4'hF);
        bus_write(1, 2'd0, 32'h9, 4'hF);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        for (int a = 0; a < 4; a++) begin
            read_reg(1, 2'(a), v);
            n_total++;
            if (v !== 32'd0) $display("FAIL midreset_rdata addr%0d got %h want 0", a, v);
            else n_pass++;
        end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            n_total++;
            if (irq1 !== 1'b0) $display("FAIL midreset_irq k%0d got %b want 0", k, irq1);
            else n_pass++;
        end
    endtask

    task automatic test_preset_during_cnt();
        logic [31:0] v;
        do_reset();
        bus_write(1, 2'd1, 32'd5, 4'hF);
        bus_write(1, 2'd0, 32'h1, 4'hF);
        bus_write(1, 2'd1, 32'd100, 4'hF);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            read_reg(1, 2'd2, v);
            n_total++;
            if (v !== 32'(3 - k)) $display("FAIL preset_mid k%0d got %0d want %0d", k, v, 3 - k);
            else n_pass++;
        end
    endtask

    task automatic test_restart();
        logic [31:0] v;
        do_reset();
        bus_write(1, 2'd1, 32'd6, 4'hF);
        bus_write(1, 2'd0, 32'h1, 4'hF);
        @(negedge clk);
        bus_write(1, 2'd0, 32'h0, 4'hF);
        @(negedge clk);
        read_reg(1, 2'd2, v);
        n_total++;
        if (v !== 32'd4) $display("FAIL restart_hold got %0d want 4", v);
        else n_pass++;
        bus_write(1, 2'd0, 32'h1, 4'hF);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            read_reg(1, 2'd2, v);
            n_total++;
            if (v !== 32'(6 - k)) $display("FAIL restart_load k%0d got %0d want %0d", k, v, 6 - k);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [31:0] v, ctrl, exp_ctrl;
        int d, p, preset, len, per, ncyc, j, exp_cnt;
        logic [1:0] mode;
        logic im, auto_rl, exp_irq;
        for (int it = 0; it < 16; it++) begin
            d = ($urandom % 2 == 0) ? 1 : 4;
            p = d;
            preset = $urandom_range(0, 5);
            mode = 2'($urandom % 4);
            im = 1'($urandom % 2);
            auto_rl = (mode == 2'd1);
            len = ((preset > 1) ? preset : 1) * p;
            per = len + 1;
            ncyc = 3 * per + 3;
            ctrl = {28'd0, im, mode, 1'b1};
            do_reset();
            bus_write(d, 2'd1, 32'(preset), 4'hF);
            bus_write(d, 2'd0, ctrl, 4'hF);
            for (int k = 0; k < ncyc; k++) begin
                @(negedge clk);
                j = auto_rl ? (k % per) : ((k < len) ? k : len);
                exp_cnt = (j < len && preset > j / p) ? preset - j / p : 0;
                exp_irq = im & (j == len);
                read_reg(d, 2'd2, v);
                n_total++;
                if (v !== 32'(exp_cnt))
                    $display("FAIL rand_count it%0d k%0d got %0d want %0d", it, k, v, exp_cnt);
                else n_pass++;
                n_total++;
                if (irq_of(d) !== exp_irq)
                    $display("FAIL rand_irq it%0d k%0d got %b want %b", it, k, irq_of(d), exp_irq);
                else n_pass++;
            end
            exp_ctrl = auto_rl ? ctrl : {28'd0, im, mode, 1'b0};
            read_reg(d, 2'd0, v);
            n_total++;
            if (v !== exp_ctrl) $display("FAIL rand_ctrl it%0d got %h want %h", it, v, exp_ctrl);
            else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b0; sel1 = 1'b0; sel4 = 1'b0; we = 1'b0;
        addr = 2'd0; mask = 4'h0; wdata = 32'd0;
        test_reset();
        test_bytelanes();
        test_oneshot();
        test_autoreload();
        test_prescale();
        test_no_im();
        test_reset_midcount();
        test_preset_during_cnt();
        test_restart();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pr_timer.md
PR_TIMER -- requirements
Module: pr_timer

Interface
REQ-001 SHALL have parameter PRESCALE, default 1, meaning clk cycles per count tick; legal range 1..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port sel  input  1  device select from the processor-bus bridge.
REQ-005 SHALL have port addr  input  2  word address bits [3:2]: 0=CTRL, 1=PRESET, 2=COUNT, 3=unmapped.
REQ-006 SHALL have port we  input  1  write strobe, valid only with sel=1.
REQ-007 SHALL have port mask  input  4  byte-lane enables; bit i enables wdata[8i+7:8i].
REQ-008 SHALL have port wdata  input  32  write data.
REQ-009 SHALL have port rdata  output  32  read data.
REQ-010 SHALL have port irq  output  1  interrupt request to one processor HWInt line.

Function
REQ-011 SHALL define CTRL as: bit0 EN (enable), bits[2:1] MODE (0=one-shot, 1=auto-reload, 2/3 treated as 0), bit3 IM (interrupt mask); bits[31:4] read 0 and ignore writes.
REQ-012 SHALL define PRESET as a 32-bit read/write register and COUNT as a 32-bit read-only register; writes to COUNT or addr 3 are ignored.
REQ-013 SHALL perform a write at the clk edge where sel=1 and we=1, updating only the byte lanes whose mask bit is 1.
REQ-014 SHALL drive rdata combinationally: the addressed register when sel=1, 0 for addr 3 or sel=0; no read side effects.
REQ-015 SHALL implement FSM states IDLE, CNT, INT, plus a prescaler counter psc.
REQ-016 IDLE: when EN=1 at an edge, SHALL load COUNT<=PRESET, psc<=0 and go to CNT; otherwise remain in IDLE with COUNT held.
REQ-017 CNT: when EN=0 at an edge, SHALL go to IDLE with COUNT held.
REQ-018 CNT: a tick SHALL occur on the edge where psc==PRESCALE-1 (psc<=0); on other edges psc increments.
REQ-019 CNT: on a tick, if COUNT<=1, SHALL set COUNT<=0, set irq_flag and go to INT; otherwise COUNT<=COUNT-1.
REQ-020 INT, MODE one-shot: SHALL clear EN and go to IDLE at the next edge; irq_flag stays set until any write to CTRL.
REQ-021 INT, MODE auto-reload: SHALL load COUNT<=PRESET, psc<=0, clear irq_flag and go to CNT at the next edge, giving a one-cycle flag pulse.
REQ-022 irq SHALL equal irq_flag AND IM, registered-state-driven with no combinational path from bus inputs.
REQ-023 Timing: EN written at edge N SHALL give COUNT=PRESET after edge N+1 and entry into INT at edge N+1+max(PRESET,1)*PRESCALE.
REQ-024 Auto-reload period SHALL be max(PRESET,1)*PRESCALE+1 cycles between INT entries.
REQ-025 PRESET writes during CNT SHALL NOT affect COUNT until the next load.
REQ-026 A CTRL write in the same edge as an FSM update of EN SHALL take precedence (bus write wins), and SHALL clear irq_flag.
REQ-027 Clearing EN mid-count then re-setting it SHALL restart from PRESET (fresh load via IDLE).

Reset
REQ-028 When reset=0, SHALL immediately set CTRL=0, PRESET=0, COUNT=0, psc=0, irq_flag=0, state=IDLE; irq=0 and rdata reads 0 for every address.
REQ-029 Release of reset SHALL take effect at the first clk edge with reset=1; reset asserted mid-count SHALL abort the count with no irq.

Verification
REQ-030 PRESCALE=1, PRESET=3, write CTRL=0x9 at edge N -> COUNT 3,2,1,0 after edges N+1..N+4; irq=1 from N+4; CTRL reads 0x8 after N+5; irq held until CTRL write, then 0.
REQ-031 PRESCALE=1, PRESET=2, CTRL=0xB (auto-reload, IM=1) -> irq one-cycle pulses every 3 cycles; COUNT reloads to 2 each time.
REQ-032 PRESCALE=4, PRESET=0, CTRL=0x9 at edge N -> INT entered at edge N+5, irq=1.
REQ-033 Write PRESET=0x12345678 with mask=0b0101 over PRESET=0 -> PRESET reads 0x00340078; write to COUNT ignored; addr 3 reads 0.
REQ-034 CTRL=0x1 (IM=0) expiry -> irq stays 0 although one-shot completes and EN clears; reset=0 mid-count -> all registers 0 asynchronously, irq=0.
